// File: rtl/pipeline_stall_controller_pkg.sv
// Shared encodings and constants for the pipeline stall controller and its hazard comparator.
package pipeline_stall_controller_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LU_STALL = 2'd1,
        MEM_WAIT = 2'd2,
        FLUSH    = 2'd3
    } ctl_state_e;

    localparam int REG_ZERO = 0;
    localparam int CNT_W    = 4;

    // The cycle that enters a multi-cycle state is itself the first cycle, so preload one less.
    function automatic logic [CNT_W-1:0] cnt_preload(input int cycles);
        return CNT_W'(cycles - 1);
    endfunction

endpackage

// File: rtl/pipeline_stall_controller_hazard_detect.sv
// Combinational load-use hazard comparator, shared with the forwarding unit.
module pipeline_hazard_detect
    import pipeline_stall_controller_pkg::*;
#(
    parameter int REG_W = 5
) (
    input  logic             ex_mem_read,
    input  logic [REG_W-1:0] ex_rt,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_uses_rt,
    output logic             hz
);

    logic rs_match;
    logic rt_match;

    assign rs_match = (ex_rt == id_rs);
    assign rt_match = id_uses_rt && (ex_rt == id_rt);

    // A load into $zero never produces a real value, so it can never cause a hazard.
    assign hz = ex_mem_read && (ex_rt != REG_W'(REG_ZERO)) && (rs_match || rt_match);

endmodule

// File: rtl/pipeline_stall_controller.sv
// PC / IF-ID / ID-EX sequencing: load-use stalls, wrong-path flushes and memory-wait freezes.
// Optional build macro STALL_PERF_COUNTERS_EN adds 32-bit bubble, hold and flush cycle counters.
module pipeline_stall_controller
    import pipeline_stall_controller_pkg::*;
#(
    parameter int LU_STALL_CYCLES = 1,
    parameter int FLUSH_CYCLES    = 1,
    parameter int REG_W           = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_uses_rt,
    input  logic             ex_mem_read,
    input  logic [REG_W-1:0] ex_rt,
    input  logic             branch_taken,
    input  logic             jump,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             if_id_flush,
    output logic             id_ex_bubble,
    output logic             ex_mem_hold,
    output logic [1:0]       ctl_state
`ifdef STALL_PERF_COUNTERS_EN
    ,
    output logic [31:0]      lu_stall_count,
    output logic [31:0]      mem_stall_count,
    output logic [31:0]      flush_count
`endif
);

    ctl_state_e       state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;

    logic hz;
    logic ms;
    logic redirect;
    logic pcw_next, ifw_next, flush_next, bubble_next, hold_next;

    pipeline_hazard_detect #(
        .REG_W(REG_W)
    ) u_hazard_detect (
        .ex_mem_read(ex_mem_read),
        .ex_rt      (ex_rt),
        .id_rs      (id_rs),
        .id_rt      (id_rt),
        .id_uses_rt (id_uses_rt),
        .hz         (hz)
    );

    assign ms       = mem_req && !mem_ready;
    assign redirect = branch_taken || jump;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= RUN;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        pcw_next    = 1'b1;
        ifw_next    = 1'b1;
        flush_next  = 1'b0;
        bubble_next = 1'b0;
        hold_next   = 1'b0;

        if (ms) begin
            // Freeze everything; stall/flush progress resumes once memory answers.
            pcw_next  = 1'b0;
            ifw_next  = 1'b0;
            hold_next = 1'b1;
            if (state_reg == RUN) begin
                state_next = MEM_WAIT;
            end
        end else begin
            case (state_reg)
                RUN, MEM_WAIT: begin
                    state_next = RUN;
                    if (hz) begin
                        pcw_next    = 1'b0;
                        ifw_next    = 1'b0;
                        bubble_next = 1'b1;
                        if (LU_STALL_CYCLES > 1) begin
                            state_next = LU_STALL;
                            cnt_next   = cnt_preload(LU_STALL_CYCLES);
                        end
                    end else if (redirect) begin
                        flush_next = 1'b1;
                        if (FLUSH_CYCLES > 1) begin
                            state_next = FLUSH;
                            cnt_next   = cnt_preload(FLUSH_CYCLES);
                        end
                    end
                end
                LU_STALL: begin
                    pcw_next    = 1'b0;
                    ifw_next    = 1'b0;
                    bubble_next = 1'b1;
                    cnt_next    = (cnt_reg != '0) ? cnt_reg - CNT_W'(1) : '0;
                    if (cnt_reg <= CNT_W'(1)) begin
                        state_next = RUN;
                    end
                end
                FLUSH: begin
                    ifw_next   = 1'b0;
                    flush_next = 1'b1;
                    cnt_next   = (cnt_reg != '0) ? cnt_reg - CNT_W'(1) : '0;
                    if (cnt_reg <= CNT_W'(1)) begin
                        state_next = RUN;
                    end
                end
                default: begin
                    state_next = RUN;
                end
            endcase
        end
    end

    // Reset forces a NOP into IF/ID and a bubble into ID/EX without waiting for a clock edge.
    assign pc_write     = reset && pcw_next;
    assign if_id_write  = reset && ifw_next;
    assign if_id_flush  = !reset || flush_next;
    assign id_ex_bubble = !reset || bubble_next;
    assign ex_mem_hold  = reset && hold_next;
    assign ctl_state    = state_reg;

`ifdef STALL_PERF_COUNTERS_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lu_stall_count  <= '0;
            mem_stall_count <= '0;
            flush_count     <= '0;
        end else begin
            if (id_ex_bubble) lu_stall_count  <= lu_stall_count + 32'd1;
            if (ex_mem_hold)  mem_stall_count <= mem_stall_count + 32'd1;
            if (if_id_flush)  flush_count     <= flush_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Directed-vector bench for pipeline_stall_controller (LU_STALL_CYCLES=2, FLUSH_CYCLES=2) with a queue scoreboard.
module tb_pipeline_stall_controller;

    localparam int REG_W = 5;

    // Expected vector layout: {pc_write, if_id_write, if_id_flush, id_ex_bubble, ex_mem_hold, ctl_state[1:0]}
    localparam logic [6:0] E_RST      = 7'b0011000;
    localparam logic [6:0] E_IDLE     = 7'b1100000;
    localparam logic [6:0] E_HZ_RUN   = 7'b0001000;
    localparam logic [6:0] E_HZ_LU    = 7'b0001001;
    localparam logic [6:0] E_BR_RUN   = 7'b1110000;
    localparam logic [6:0] E_BR_MW    = 7'b1110010;
    localparam logic [6:0] E_BR_FL    = 7'b1010011;
    localparam logic [6:0] E_HOLD_RUN = 7'b0000100;
    localparam logic [6:0] E_HOLD_LU  = 7'b0000101;
    localparam logic [6:0] E_HOLD_MW  = 7'b0000110;
    localparam logic [6:0] E_HOLD_FL  = 7'b0000111;

    logic             clk;
    logic             reset;
    logic [REG_W-1:0] id_rs, id_rt, ex_rt;
    logic             id_uses_rt, ex_mem_read, branch_taken, jump, mem_req, mem_ready;
    logic             pc_write, if_id_write, if_id_flush, id_ex_bubble, ex_mem_hold;
    logic [1:0]       ctl_state;
`ifdef STALL_PERF_COUNTERS_EN
    logic [31:0]      lu_stall_count, mem_stall_count, flush_count;
`endif

    pipeline_stall_controller #(
        .LU_STALL_CYCLES(2),
        .FLUSH_CYCLES   (2),
        .REG_W          (REG_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .id_uses_rt  (id_uses_rt),
        .ex_mem_read (ex_mem_read),
        .ex_rt       (ex_rt),
        .branch_taken(branch_taken),
        .jump        (jump),
        .mem_req     (mem_req),
        .mem_ready   (mem_ready),
        .pc_write    (pc_write),
        .if_id_write (if_id_write),
        .if_id_flush (if_id_flush),
        .id_ex_bubble(id_ex_bubble),
        .ex_mem_hold (ex_mem_hold),
        .ctl_state   (ctl_state)
`ifdef STALL_PERF_COUNTERS_EN
        ,
        .lu_stall_count (lu_stall_count),
        .mem_stall_count(mem_stall_count),
        .flush_count    (flush_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [6:0] exp_q[$];
    string      name_q[$];
    int         n_vec = 0;
    int         n_bad = 0;

    // Inputs change #1 after the rising edge; the response is checked on the falling edge.
    task automatic step(input string name, input logic rst, input logic rd, input int ert,
                        input int rs, input int rt, input logic urt, input logic br,
                        input logic jmp, input logic mreq, input logic mrdy,
                        input logic [6:0] exp_v);
        @(posedge clk);
        #1;
        reset        = rst;
        ex_mem_read  = rd;
        ex_rt        = REG_W'(ert);
        id_rs        = REG_W'(rs);
        id_rt        = REG_W'(rt);
        id_uses_rt   = urt;
        branch_taken = br;
        jump         = jmp;
        mem_req      = mreq;
        mem_ready    = mrdy;
        exp_q.push_back(exp_v);
        name_q.push_back(name);
    endtask

    always @(negedge clk) begin
        logic [6:0] got, want;
        string      nm;
        if (exp_q.size() > 0) begin
            want = exp_q.pop_front();
            nm   = name_q.pop_front();
            got  = {pc_write, if_id_write, if_id_flush, id_ex_bubble, ex_mem_hold, ctl_state};
            n_vec++;
            if (got !== want) begin
                n_bad++;
                $display("FAIL %s: got %b required %b (pcw,ifw,flush,bubble,hold,state)", nm, got, want);
            end else begin
                $display("vec %0d %s ok %b", n_vec, nm, got);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached with %0d vectors pending", exp_q.size());
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; ex_mem_read = 1'b0; ex_rt = '0; id_rs = '0; id_rt = '0;
        id_uses_rt = 1'b0; branch_taken = 1'b0; jump = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;

        //    name             rst rd  ert rs rt urt br jmp mreq mrdy expected
        step("reset_0",        0,  0,  0,  0, 0, 0,  0, 0,  0,   0,   E_RST);
        step("reset_1",        0,  0,  0,  0, 0, 0,  0, 0,  0,   0,   E_RST);
        step("reset_2",        0,  0,  0,  0, 0, 0,  0, 0,  0,   0,   E_RST);
        step("first_run",      1,  0,  0,  0, 0, 0,  0, 0,  0,   0,   E_IDLE);
        step("lu_rs_run",      1,  1,  8,  8, 0, 0,  0, 0,  0,   0,   E_HZ_RUN);
        step("lu_rs_stall",    1,  1,  8,  8, 0, 0,  0, 0,  0,   0,   E_HZ_LU);
        step("lu_rs_done",     1,  0,  8,  8, 0, 0,  0, 0,  0,   0,   E_IDLE);
        step("load_r0",        1,  1,  0,  0, 0, 1,  0, 0,  0,   0,   E_IDLE);
        step("rt_not_used",    1,  1,  5,  3, 5, 0,  0, 0,  0,   0,   E_IDLE);
        step("lu_rt_run",      1,  1,  5,  3, 5, 1,  0, 0,  0,   0,   E_HZ_RUN);
        step("lu_rt_stall",    1,  1,  5,  3, 5, 1,  0, 0,  0,   0,   E_HZ_LU);
        step("lu_rt_done",     1,  0,  0,  0, 0, 0,  0, 0,  0,   0,   E_IDLE);
        step("branch_run",     1,  0,  0,  0, 0, 0,  1, 0,  0,   0,   E_BR_RUN);
        step("branch_flush",   1,  0,  0,  0, 0, 0,  1, 0,  0,   0,   E_BR_FL);
        step("branch_done",    1,  0,  0,  0, 0, 0,  0, 0,  0,   0,   E_IDLE);
        step("ms_lu_enter",    1,  1,  8,  8, 0, 0,  0, 0,  0,   0,   E_HZ_RUN);
        step("ms_lu_hold0",    1,  1,  8,  8, 0, 0,  0, 0,  1,   0,   E_HOLD_LU);
        step("ms_lu_hold1",    1,  1,  8,  8, 0, 0,  0, 0,  1,   0,   E_HOLD_LU);
        step("ms_lu_hold2",    1,  1,  8,  8, 0, 0,  0, 0,  1,   0,   E_HOLD_LU);
        step("ms_lu_hold3",    1,  1,  8,  8, 0, 0,  0, 0,  1,   0,   E_HOLD_LU);
        step("ms_lu_resume",   1,  1,  8,  8, 0, 0,  0, 0,  1,   1,   E_HZ_LU);
        step("ms_lu_done",     1,  0,  0,  0, 0, 0,  0, 0,  0,   0,   E_IDLE);
        step("ms_run_hold",    1,  0,  0,  0, 0, 0,  0, 0,  1,   0,   E_HOLD_RUN);
        step("ms_wait_hold",   1,  0,  0,  0, 0, 0,  0, 0,  1,   0,   E_HOLD_MW);
        step("ms_wait_jump",   1,  0,  0,  0, 0, 0,  0, 1,  1,   1,   E_BR_MW);
        step("jump_flush",     1,  0,  0,  0, 0, 0,  0, 0,  0,   0,   E_BR_FL);
        step("jump_done",      1,  0,  0,  0, 0, 0,  0, 0,  0,   0,   E_IDLE);
        step("hz_br_run",      1,  1,  8,  8, 0, 0,  1, 0,  0,   0,   E_HZ_RUN);
        step("hz_br_stall",    1,  1,  8,  8, 0, 0,  1, 0,  0,   0,   E_HZ_LU);
        step("br_after_stall", 1,  0,  8,  8, 0, 0,  1, 0,  0,   0,   E_BR_RUN);
        step("flush_ms_hold",  1,  0,  0,  0, 0, 0,  0, 0,  1,   0,   E_HOLD_FL);
        step("flush_reset",    0,  0,  0,  0, 0, 0,  0, 0,  1,   0,   E_RST);
        step("post_reset_run", 1,  0,  0,  0, 0, 0,  0, 0,  0,   0,   E_IDLE);

        repeat (2) @(posedge clk);
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d expected vectors never checked, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/pipeline_stall_controller.md
Name: pipeline_stall_controller

Overview:
- Sequences the IF/ID and ID/EX pipeline registers and the PC of the pipelined MIPS core.
- Detects load-use hazards and inserts multi-cycle stalls.
- Squashes wrong-path fetches after taken branches/jumps.
- Freezes the whole front end while data memory is not ready.
- All control outputs are valid before the falling clock edge on which the pipeline registers capture.

Parameters:
- LU_STALL_CYCLES, 1, bubbles inserted per load-use hazard (1..15).
- FLUSH_CYCLES, 1, wrong-path fetches squashed per taken branch/jump (1..15).
- REG_W, 5, register-specifier width.

Ports:
- clk  in  1  clock; state/counters update on rising edge.
- reset  in  1  asynchronous, active-low reset.
- id_rs  in  REG_W  rs field of the instruction in ID.
- id_rt  in  REG_W  rt field of the instruction in ID.
- id_uses_rt  in  1  ID instruction reads rt as a source.
- ex_mem_read  in  1  instruction in EX is a load.
- ex_rt  in  REG_W  destination of the load in EX.
- branch_taken  in  1  branch in ID resolved taken.
- jump  in  1  jump in ID.
- mem_req  in  1  MEM stage issuing a data-memory access.
- mem_ready  in  1  data memory completes this cycle.
- pc_write  out  1  PC load enable.
- if_id_write  out  1  IF/ID capture enable.
- if_id_flush  out  1  IF/ID clears to 0 (NOP).
- id_ex_bubble  out  1  ID/EX loads control zeros.
- ex_mem_hold  out  1  EX/MEM and MEM/WB hold.
- ctl_state  out  2  current FSM state.

Behaviour:
- Reset is asynchronous, active-low. While reset=0:
  - state=RUN, counter=0.
  - pc_write=0, if_id_write=0, if_id_flush=1, id_ex_bubble=1, ex_mem_hold=0.
- States: RUN=0, LU_STALL=1, MEM_WAIT=2, FLUSH=3.
- Load-use hazard (hz): ex_mem_read && ex_rt!=0 && (ex_rt==id_rs || (id_uses_rt && ex_rt==id_rt)).
- Memory stall (ms): mem_req && !mem_ready.
- Priority each cycle: ms > hz/LU_STALL > branch/jump flush.
- Any state, ms=1:
  - pc_write=0, if_id_write=0, ex_mem_hold=1, if_id_flush=0, id_ex_bubble=0.
  - Counter frozen.
  - From RUN, next state is MEM_WAIT. From LU_STALL/FLUSH, the state is retained.
- MEM_WAIT:
  - Outputs as for ms=1 while mem_ready=0.
  - First cycle with mem_ready=1 gives normal RUN outputs and next=RUN. The pending hz/branch is evaluated that same cycle, exactly as in RUN.
- RUN, hz=1:
  - pc_write=0, if_id_write=0, id_ex_bubble=1.
  - If LU_STALL_CYCLES>1: next=LU_STALL, counter=LU_STALL_CYCLES-1.
  - Otherwise stay in RUN.
  - branch_taken/jump are ignored this cycle; the ID instruction is re-evaluated after the stall.
- LU_STALL:
  - Same outputs as the RUN hz=1 case.
  - Counter decrements per cycle; at counter==1, next=RUN.
- RUN, no hz, branch_taken|jump:
  - pc_write=1, if_id_write=1, if_id_flush=1.
  - If FLUSH_CYCLES>1: next=FLUSH, counter=FLUSH_CYCLES-1.
- FLUSH:
  - pc_write=1, if_id_flush=1.
  - Counter decrements; at counter==1, next=RUN.
  - Branch/jump inputs are ignored.
- RUN, idle: pc_write=1, if_id_write=1, all others 0.
- Counter is 4 bits and never wraps; it saturates at 0.
- Reset asserted mid-stall or mid-flush aborts immediately to RUN.

Optional Feature:
- Macro STALL_PERF_COUNTERS_EN.
- When defined, adds outputs:
  - lu_stall_count (32 bits): increments each cycle id_ex_bubble=1 outside reset.
  - mem_stall_count (32 bits): increments each cycle ex_mem_hold=1.
  - flush_count (32 bits): increments each cycle if_id_flush=1 outside reset.
- All three counters clear on reset and wrap modulo 2^32.
- When undefined, these ports and registers are absent; behaviour is otherwise identical.

Decomposition:
- Shared package holds:
  - state encodings RUN/LU_STALL/MEM_WAIT/FLUSH.
  - REG_ZERO=0.
  - CNT_W=4.
- One natural sub-module: pipeline_hazard_detect, a combinational hz comparator reused by the forwarding unit.

Test Plan:
- Reset held low 3 cycles, then released with idle inputs → outputs match reset values during reset; pc_write=1, if_id_write=1 on the first cycle after.
- ex_mem_read=1, ex_rt=8, id_rs=8, LU_STALL_CYCLES=2 → two cycles of pc_write=0 and id_ex_bubble=1, then RUN.
- ex_rt=0 with id_rs=0 and ex_mem_read=1 → no stall.
- branch_taken=1, FLUSH_CYCLES=2 → if_id_flush=1 for 2 cycles, pc_write=1 throughout; a second branch_taken during FLUSH is ignored.
- mem_req=1, mem_ready=0 for 4 cycles arriving in LU_STALL with counter=1 → ex_mem_hold=1 for 4 cycles; the remaining stall cycle then executes.
- hz and branch_taken together → stall only. After the stall, with branch_taken still 1, a flush occurs. Reset pulsed mid-flush → ctl_state=0 immediately.
